bcd_addsub_seq: RTL and testbench
=================================

Name: bcd_addsub_seq

Overview:
Parametrised multi-digit packed-BCD adder/subtractor. It is the sequential successor to the single-digit combinational BCD adder. It processes one decimal digit per clock, least-significant digit first, and carries between digits internally. A start/busy/done handshake lets a controller launch an operation and collect the result. Used by the datapath wherever decimal operands wider than one digit are summed or differenced.

Parameters:
DIGITS, 4, number of BCD digits per operand (minimum 1); operand width is 4*DIGITS bits.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous, active-low reset
start  input  1  launch request; sampled only when idle
sub  input  1  mode, sampled with start: 0 gives a+b+cin; 1 gives a-b-cin
a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
b  input  4*DIGITS  operand B, packed BCD
cin  input  1  carry-in for add mode; borrow-in for sub mode
busy  output  1  operation in progress
done  output  1  one-cycle pulse: s, cout and invalid are now valid
s  output  4*DIGITS  result, packed BCD
cout  output  1  add: decimal carry-out; sub: 1 = no borrow (A >= B+cin), 0 = borrow (s holds the ten's complement)
invalid  output  1  at least one input digit of a or b was greater than 9

Behaviour:
- Reset (rst_n low, asynchronous): FSM goes to IDLE; busy, done, s, cout and invalid all go to 0; digit counter and internal registers clear. Assertion mid-operation aborts the operation with no done pulse.
- FSM states are IDLE, RUN and DONE.
- IDLE, start=1 at an edge (edge 0):
  - latch a, b, sub and carry-in; carry-in is cin in add mode and ~cin in sub mode.
  - evaluate invalid over all 2*DIGITS input digits.
  - digit index goes to 0; go to RUN; busy=1.
- RUN: one digit per edge, on edges 1..DIGITS.
  - b' = b_d in add mode; b' = (9 - b_d) mod 16 in sub mode (nines' complement).
  - t = a_d + b' + c, a 5-bit value.
  - If t > 9: digit = (t + 6)[3:0], c = 1. Otherwise: digit = t[3:0], c = 0.
  - Each digit goes into an internal result shift register; s is not updated during RUN.
- At edge DIGITS: s gets the full result, cout gets the final c, invalid is registered, busy=0, done=1; go to DONE.
- DONE lasts exactly one cycle. done=0 after the next edge and the FSM returns to IDLE.
  - start=1 during the DONE cycle is accepted as a new launch; the FSM goes straight to RUN, giving back-to-back operation.
- Latency from the start-sampling edge to done high is DIGITS edges. Throughput is one operation per DIGITS+1 cycles.
- start while busy is ignored; in-flight operands are unaffected by input changes after edge 0.
- s, cout and invalid hold their values from done until the next completion or reset. They are not cleared on start.
- Invalid digits:
  - computation still follows the exact correction rule above, with no saturation.
  - invalid is a flag only and does not suppress done.
- DIGITS=1: the single digit is processed at edge 1, done follows at once, and behaviour otherwise matches the general case.
- Counter width is clog2(DIGITS), minimum 1 bit.

Test Plan (DIGITS=4):
1. Reset then idle: rst_n low -> busy=0, done=0, s=0000, cout=0, invalid=0; start held low -> no change.
2. Add: a=1234, b=5678, sub=0, cin=0, start for 1 cycle -> busy for 4 cycles; done pulse 4 edges after start; s=6912, cout=0, invalid=0. Repeat with cin=1 -> s=6913.
3. Carry ripple: a=9999, b=0001, cin=0 -> s=0000, cout=1. Then a=9999, b=9999, cin=1 -> s=9999, cout=1.
4. Subtract:
   - a=5000, b=1234, sub=1, cin=0 -> s=3766, cout=1.
   - a=0100, b=0200, sub=1, cin=0 -> s=9900, cout=0 (ten's complement).
   - a=0000, b=0000, sub=1, cin=1 -> s=9999, cout=0.
5. Invalid and handshake:
   - a=000A, b=0001 -> s=0011, invalid=1, done still pulses.
   - A second start pulsed mid-RUN with new operands is ignored; the first result is unchanged and no extra done appears.
   - start asserted in the DONE cycle -> second result completes 5 cycles after the first done.
6. Reset mid-operation: start 1234+5678, drop rst_n after 2 RUN cycles -> outputs 0 immediately, no done. After release, start 0001+0002 -> s=0003.

Source files
------------

// File: rtl/bcd_addsub_seq_if.sv
// Start/busy/done handshake and operand/result bus of the sequential packed-BCD adder/subtractor.
interface bcd_addsub_seq_if #(parameter int DIGITS = 4);
  logic                  start;
  logic                  sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   s;
  logic                  cout;
  logic                  invalid;

  modport master (output start, sub, a, b, cin,
                  input  busy, done, s, cout, invalid);
  modport slave  (input  start, sub, a, b, cin,
                  output busy, done, s, cout, invalid);
endinterface

// File: rtl/bcd_addsub_seq.sv
// Multi-digit packed-BCD add/subtract, one digit per clock LSD first; done pulses DIGITS edges after start.
// Start is ignored while busy; a start during the done cycle launches the next operation back-to-back.
module bcd_addsub_seq #(
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_addsub_seq_if.slave  bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_r, b_r, res_r, res_nx;
  logic            sub_r, c_r, inv_r, in_inv;
  logic [CW-1:0]   cnt;
  logic [CW+1:0]   idx;
  logic [3:0]      a_d, b_d, b_p, dig;
  logic [4:0]      t, t6;
  logic            c_nx, last;

  always_comb begin
    in_inv = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) in_inv = 1'b1;
    end
  end

  // Subtraction is A + nines'(B) + ~borrow; an out-of-range B digit wraps mod 16.
  always_comb begin
    idx    = {cnt, 2'b00};
    a_d    = a_r[idx +: 4];
    b_d    = b_r[idx +: 4];
    b_p    = sub_r ? (4'd9 - b_d) : b_d;
    t      = {1'b0, a_d} + {1'b0, b_p} + {4'b0000, c_r};
    t6     = t + 5'd6;
    c_nx   = (t > 5'd9);
    dig    = c_nx ? t6[3:0] : t[3:0];
    res_nx = res_r;
    res_nx[idx +: 4] = dig;
    last   = (cnt == CW'(DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      res_r       <= '0;
      sub_r       <= 1'b0;
      c_r         <= 1'b0;
      inv_r       <= 1'b0;
      cnt         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.s       <= '0;
      bus.cout    <= 1'b0;
      bus.invalid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            sub_r    <= bus.sub;
            c_r      <= bus.sub ? ~bus.cin : bus.cin;
            inv_r    <= in_inv;
            cnt      <= '0;
            res_r    <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state    <= IDLE;
          end
        end
        RUN: begin
          res_r <= res_nx;
          c_r   <= c_nx;
          cnt   <= cnt + 1'b1;
          if (last) begin
            bus.s       <= res_nx;
            bus.cout    <= c_nx;
            bus.invalid <= inv_r;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Scoreboard bench for bcd_addsub_seq (DIGITS=4): directed vectors, expected results queued at issue.
module tb_bcd_addsub_seq;
  localparam int DIGITS = 4;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        inv;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  int   done_cnt;
  exp_t sb[$];

  bcd_addsub_seq_if #(.DIGITS(DIGITS)) bus ();

  bcd_addsub_seq #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_s",     32'(bus.s),       32'(e.s));
        chk("result_cout",  32'(bus.cout),    32'(e.cout));
        chk("result_inv",   32'(bus.invalid), 32'(e.inv));
        chk("done_latency", 32'(cyc),         32'(e.cyc));
        chk("busy_at_done", 32'(bus.busy),    32'd0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  // Drive at a negedge; the following posedge samples start.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic cin, input logic [15:0] es, input logic ec,
                        input logic ei, input bit expect_result);
    exp_t e;
    bus.a = a; bus.b = b; bus.sub = sub; bus.cin = cin; bus.start = 1'b1;
    if (expect_result) begin
      e.s = es; e.cout = ec; e.inv = ei; e.cyc = cyc + 1 + DIGITS;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (done_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%0d expected=%0d", done_cnt, target);
    end
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                    input logic cin, input logic [15:0] es, input logic ec, input logic ei);
    int tgt;
    wait_idle();
    @(negedge clk);
    tgt = done_cnt + 1;
    launch(a, b, sub, cin, es, ec, ei, 1'b1);
    #1 chk("busy_after_start", 32'(bus.busy), 32'd1);
    wait_done(tgt);
  endtask

  initial begin
    checks = 0; failures = 0; done_cnt = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    #23;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_s",    32'(bus.s),    32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_inv",  32'(bus.invalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_s",    32'(bus.s),    32'd0);

    op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
    op(16'h1234, 16'h5678, 1'b0, 1'b1, 16'h6913, 1'b0, 1'b0);
    op(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0);
    op(16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b1, 1'b0);
    op(16'h0100, 16'h0200, 1'b1, 1'b0, 16'h9900, 1'b0, 1'b0);
    op(16'h0000, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0);
    op(16'h000A, 16'h0001, 1'b0, 1'b0, 16'h0011, 1'b0, 1'b1);

    // Start pulsed mid-RUN with different operands must be ignored.
    begin
      int tgt;
      wait_idle();
      @(negedge clk);
      tgt = done_cnt + 1;
      launch(16'h2222, 16'h3333, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1 bus.a = 16'h1111; bus.b = 16'h1111; bus.sub = 1'b1; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(tgt);
      repeat (6) @(negedge clk);
      chk("no_extra_done", 32'(done_cnt), 32'(tgt));
    end

    // Start during the DONE cycle: second result 5 cycles after first done.
    begin
      int tgt;
      int n;
      wait_idle();
      @(negedge clk);
      tgt = done_cnt + 2;
      launch(16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1);
      n = 0;
      while (!bus.done && n < 20) begin
        @(negedge clk);
        n++;
      end
      launch(16'h0500, 16'h0499, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b1);
      #1 chk("b2b_busy", 32'(bus.busy), 32'd1);
      wait_done(tgt);
    end

    // Asynchronous reset mid-operation aborts without a done pulse.
    begin
      int tgt;
      wait_idle();
      @(negedge clk);
      tgt = done_cnt;
      launch(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_s",    32'(bus.s),    32'd0);
      chk("abort_cout", 32'(bus.cout), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt), 32'(tgt));
    end
    op(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
